// File: rtl/ma_pipeline.sv
`default_nettype none
// ============================================================================
// Module   : ma_pipeline
// Purpose  : Memory-access stage of the five-stage SimpleRisc core. Takes the
//            EX->MA latch contents, runs any load/store over a req/ack data
//            memory port, and registers the results into the MA->RW latch.
//            Upstream stages are stalled while a transaction is in flight.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst          clock, synchronous active-high reset
//   pc, aluResult,    EX->MA latch fields (aluResult doubles as the address,
//   op2, instruction,  op2 as the store data)
//   control
//   stall             combinational: upstream latches hold while 1
//   mem_req/we/addr/  registered data-memory request, held stable until ack
//   wdata
//   mem_rdata/ack     memory response; rdata valid with ack
//   *_out             MA->RW latch
//   mem_error         sticky timeout flag
// Optional feature
//   MA_TIMEOUT_EN     when defined, an 8-bit wait counter aborts a request
//                     after TIMEOUT REQ cycles with load data 32'hDEAD_BEEF
//                     and sets mem_error. Undefined: REQ waits indefinitely
//                     and mem_error is tied to 0.
// ============================================================================
module ma_pipeline #(
  parameter int          LD_BIT    = 1,
  parameter int          ST_BIT    = 0,
  parameter logic [31:0] NOP_INSTR = 32'h6800_0000,
  parameter int          TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic [31:0] aluResult,
  input  logic [31:0] op2,
  input  logic [31:0] instruction,
  input  logic [23:0] control,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] pc_out,
  output logic [31:0] aluResult_out,
  output logic [31:0] ldResult_out,
  output logic [31:0] instruction_out,
  output logic [23:0] control_out,
  output logic        mem_error
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [31:0] c_abort_data = 32'hDEAD_BEEF;

  state_t      r_state;
  state_t      w_state_next;

  logic        w_is_ld;
  logic        w_is_st;
  logic        w_is_mem;
  logic        w_stall;
  logic        w_start;    // launch a request this edge
  logic        w_capture;  // latch takes the presented inputs (else bubble)
  logic        w_timeout;  // abort the outstanding request this edge

  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [31:0] r_ld_data;
  logic [31:0] r_pc_out;
  logic [31:0] r_alu_out;
  logic [31:0] r_ld_out;
  logic [31:0] r_instr_out;
  logic [23:0] r_ctrl_out;

  assign w_is_ld  = control[LD_BIT];
  assign w_is_st  = control[ST_BIT];
  assign w_is_mem = w_is_ld | w_is_st;

`ifdef MA_TIMEOUT_EN
  localparam logic [7:0] c_wait_last = 8'(TIMEOUT - 1);

  logic [7:0] r_wait_cnt;
  logic       r_mem_error;

  // The abort fires on the edge that would bring the count to TIMEOUT, so
  // exactly TIMEOUT REQ cycles elapse before the stage gives up.
  assign w_timeout = (r_state == S_REQ) && !mem_ack && (r_wait_cnt == c_wait_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt  <= '0;
      r_mem_error <= 1'b0;
    end else begin
      if (w_start) begin
        r_wait_cnt <= '0;
      end else if (r_state == S_REQ && !mem_ack) begin
        r_wait_cnt <= r_wait_cnt + 8'd1;
      end
      if (w_timeout) begin
        r_mem_error <= 1'b1;
      end
    end
  end

  assign mem_error = r_mem_error;
`else
  assign w_timeout = 1'b0;
  assign mem_error = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and per-cycle controls
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_stall      = 1'b0;
    w_start      = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_is_mem) begin
          w_stall      = 1'b1;
          w_start      = 1'b1;
          w_state_next = S_REQ;
        end else begin
          w_capture = 1'b1;
        end
      end
      S_REQ: begin
        w_stall = 1'b1;
        if (mem_ack || w_timeout) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        // Upstream was held through REQ, so the same instruction is still
        // presented and is now retired into the latch.
        w_capture    = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign stall = w_stall;

  // --------------------------------------------------------------------------
  // Memory port, load data and MA->RW latch
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_ld_data   <= '0;
      r_pc_out    <= '0;
      r_alu_out   <= '0;
      r_ld_out    <= '0;
      r_instr_out <= NOP_INSTR;
      r_ctrl_out  <= '0;
    end else begin
      if (w_capture) begin
        r_pc_out    <= pc;
        r_alu_out   <= aluResult;
        r_ld_out    <= (r_state == S_DONE) ? r_ld_data : 32'd0;
        r_instr_out <= instruction;
        r_ctrl_out  <= control;
      end else begin
        r_pc_out    <= '0;
        r_alu_out   <= '0;
        r_ld_out    <= '0;
        r_instr_out <= NOP_INSTR;
        r_ctrl_out  <= '0;
      end

      if (w_start) begin
        r_mem_req   <= 1'b1;
        r_mem_addr  <= aluResult;
        r_mem_wdata <= op2;
        // Both flags set resolves to a load.
        r_mem_we    <= w_is_st & ~w_is_ld;
      end

      if (r_state == S_REQ) begin
        if (mem_ack) begin
          r_mem_req <= 1'b0;
          r_ld_data <= r_mem_we ? 32'd0 : mem_rdata;
        end else if (w_timeout) begin
          r_mem_req <= 1'b0;
          r_ld_data <= c_abort_data;
        end
      end
    end
  end

  assign mem_req         = r_mem_req;
  assign mem_we          = r_mem_we;
  assign mem_addr        = r_mem_addr;
  assign mem_wdata       = r_mem_wdata;
  assign pc_out          = r_pc_out;
  assign aluResult_out   = r_alu_out;
  assign ldResult_out    = r_ld_out;
  assign instruction_out = r_instr_out;
  assign control_out     = r_ctrl_out;

endmodule
`default_nettype wire

// File: tb/tb_ma_pipeline.sv
`default_nettype none
// ============================================================================
// Module   : tb_ma_pipeline
// Purpose  : Self-checking bench for ma_pipeline. Each instruction is treated
//            as one transaction whose expected latch contents, stall window
//            and memory request follow from its type and the memory's
//            response delay.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ma_pipeline;

  localparam int          TB_TIMEOUT = 4;
  localparam logic [31:0] NOP        = 32'h6800_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc, aluResult, op2, instruction;
  logic [23:0] control;
  logic        stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic [31:0] pc_out, aluResult_out, ldResult_out, instruction_out;
  logic [23:0] control_out;
  logic        mem_error;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ma_pipeline #(
    .LD_BIT   (1),
    .ST_BIT   (0),
    .NOP_INSTR(NOP),
    .TIMEOUT  (TB_TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pc             (pc),
    .aluResult      (aluResult),
    .op2            (op2),
    .instruction    (instruction),
    .control        (control),
    .stall          (stall),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_ack        (mem_ack),
    .pc_out         (pc_out),
    .aluResult_out  (aluResult_out),
    .ldResult_out   (ldResult_out),
    .instruction_out(instruction_out),
    .control_out    (control_out),
    .mem_error      (mem_error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_latch(input string tag, input logic [31:0] p, input logic [31:0] a,
                           input logic [31:0] ld, input logic [31:0] i, input logic [23:0] c);
    chk({tag, "_pc"},    pc_out,               p);
    chk({tag, "_alu"},   aluResult_out,        a);
    chk({tag, "_ld"},    ldResult_out,         ld);
    chk({tag, "_instr"}, instruction_out,      i);
    chk({tag, "_ctrl"},  {8'd0, control_out},  {8'd0, c});
  endtask

  // Non-memory instruction: no stall, retired one cycle later, ldResult 0.
  task automatic alu_op(input string tag, input logic [31:0] p, input logic [31:0] a,
                        input logic [31:0] i, input logic [23:0] c_in, input logic stray_ack);
    logic [23:0] c;
    c = c_in;
    c[1:0] = 2'b00;
    pc = p; aluResult = a; op2 = $urandom; instruction = i; control = c;
    mem_ack = stray_ack; mem_rdata = $urandom;
    #1;
    chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
    step();
    mem_ack = 1'b0;
    chk_latch(tag, p, a, 32'd0, i, c);
    chk({tag, "_req"}, {31'd0, mem_req}, 32'd0);
  endtask

  // Memory instruction; the memory acks in REQ cycle number (delay+1).
  task automatic mem_op(input string tag, input logic [31:0] p, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] i, input logic [23:0] c,
                        input logic [31:0] rd, input int delay);
    logic        exp_we;
    logic [31:0] exp_ld;
    exp_we = c[0] & ~c[1];
    exp_ld = c[1] ? rd : 32'd0;
    pc = p; aluResult = a; op2 = d; instruction = i; control = c;
    mem_ack = 1'b0; mem_rdata = $urandom;
    #1;
    chk({tag, "_stall_idle"}, {31'd0, stall}, 32'd1);
    step();
    for (int k = 0; k <= delay; k++) begin
      chk({tag, "_stall_req"}, {31'd0, stall},   32'd1);
      chk({tag, "_req"},       {31'd0, mem_req}, 32'd1);
      chk({tag, "_addr"},      mem_addr,         a);
      chk({tag, "_we"},        {31'd0, mem_we},  {31'd0, exp_we});
      chk({tag, "_wdata"},     mem_wdata,        d);
      chk({tag, "_bubble"},    instruction_out,  NOP);
      chk({tag, "_bub_ctrl"},  {8'd0, control_out}, 32'd0);
      mem_ack   = (k == delay);
      mem_rdata = (k == delay) ? rd : $urandom;
      step();
    end
    mem_ack = 1'b0; mem_rdata = $urandom;
    chk({tag, "_stall_done"}, {31'd0, stall},   32'd0);
    chk({tag, "_req_done"},   {31'd0, mem_req}, 32'd0);
    chk({tag, "_bub_done"},   instruction_out,  NOP);
    step();
    chk_latch(tag, p, a, exp_ld, i, c);
  endtask

  initial begin
    rst = 1'b1;
    pc = '0; aluResult = '0; op2 = '0; instruction = '0; control = '0;
    mem_rdata = '0; mem_ack = 1'b0;

    // Reset and idle
    step();
    step();
    chk("rst_instr", instruction_out,         NOP);
    chk("rst_ctrl",  {8'd0, control_out},     32'd0);
    chk("rst_pc",    pc_out,                  32'd0);
    chk("rst_ld",    ldResult_out,            32'd0);
    chk("rst_stall", {31'd0, stall},          32'd0);
    chk("rst_req",   {31'd0, mem_req},        32'd0);
    chk("rst_addr",  mem_addr,                32'd0);
    chk("rst_err",   {31'd0, mem_error},      32'd0);
    rst = 1'b0;

    // Directed cases
    alu_op("alu", 32'h4, 32'h10, 32'h1234_5678, 24'h000000, 1'b0);
    mem_op("load", 32'h8, 32'h100, 32'h0, 32'hAAAA_0001, 24'h000002, 32'hCAFE_0001, 1);
    mem_op("store", 32'hC, 32'h200, 32'h55AA_55AA, 32'hBBBB_0002, 24'h000001, 32'h9999_9999, 0);
    mem_op("ldst", 32'h10, 32'h300, 32'h1111_2222, 32'hCCCC_0003, 24'h000003, 32'h7777_8888, 2);
    // Back-to-back memory ops
    mem_op("b2b_a", 32'h14, 32'h400, 32'h0, 32'hD0D0_0004, 24'h000002, 32'h0BAD_F00D, 0);
    mem_op("b2b_b", 32'h18, 32'h404, 32'h3C3C_3C3C, 32'hD0D0_0005, 24'h000001, 32'h0, 0);
    // Stray ack in IDLE is ignored
    alu_op("stray", 32'h1C, 32'h44, 32'h0F0F_0F0F, 24'hABCD00, 1'b1);

    // Reset while a request is outstanding
    pc = 32'h20; aluResult = 32'h500; op2 = 32'h0; instruction = 32'hEEEE_0006;
    control = 24'h000002; mem_ack = 1'b0;
    step();
    chk("rmid_req_before", {31'd0, mem_req}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    control = 24'h000000;
    #1;
    chk("rmid_req",   {31'd0, mem_req}, 32'd0);
    chk("rmid_stall", {31'd0, stall},   32'd0);
    chk("rmid_instr", instruction_out,  NOP);
    mem_ack = 1'b1; mem_rdata = 32'hFACE_FACE;
    step();
    mem_ack = 1'b0;
    chk("late_req",   {31'd0, mem_req}, 32'd0);
    chk("late_ld",    ldResult_out,     32'd0);
    chk("late_pc",    pc_out,           32'h20);
    chk("late_stall", {31'd0, stall},   32'd0);

`ifdef MA_TIMEOUT_EN
    // No ack: the request is abandoned after TB_TIMEOUT REQ cycles
    pc = 32'h24; aluResult = 32'h600; op2 = 32'h0; instruction = 32'hF00D_0007;
    control = 24'h000002; mem_ack = 1'b0;
    #1;
    chk("to_stall_idle", {31'd0, stall}, 32'd1);
    step();
    for (int k = 0; k < TB_TIMEOUT; k++) begin
      chk("to_stall_req", {31'd0, stall},     32'd1);
      chk("to_req",       {31'd0, mem_req},   32'd1);
      chk("to_err_early", {31'd0, mem_error}, 32'd0);
      step();
    end
    chk("to_stall_done", {31'd0, stall},     32'd0);
    chk("to_req_done",   {31'd0, mem_req},   32'd0);
    chk("to_err",        {31'd0, mem_error}, 32'd1);
    step();
    chk("to_ld",         ldResult_out,        32'hDEAD_BEEF);
    chk("to_pc",         pc_out,              32'h24);
    alu_op("to_after", 32'h28, 32'h1, 32'h0, 24'h0, 1'b0);
    chk("to_err_sticky", {31'd0, mem_error}, 32'd1);
`else
    // Without the timeout the stage simply keeps waiting
    mem_op("long_wait", 32'h24, 32'h600, 32'h0, 32'hF00D_0007, 24'h000002, 32'h1357_9BDF, 40);
    chk("no_err", {31'd0, mem_error}, 32'd0);
`endif

    // Randomized instruction mix
    for (int n = 0; n < 40; n++) begin
      int          typ;
      int          dly;
      logic [23:0] c;
      typ = $urandom_range(0, 3);
      dly = $urandom_range(0, 3);
      c   = 24'($urandom);
      c[1:0] = 2'(typ);
      if (typ == 0) begin
        alu_op($sformatf("rnd%0d_alu", n), $urandom, $urandom, $urandom, c, 1'($urandom_range(0, 1)));
      end else begin
        mem_op($sformatf("rnd%0d_mem", n), $urandom, $urandom, $urandom, $urandom, c, $urandom, dly);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
